csa_cpa_pipe: RTL
=================

// Module: csa_cpa_pipe
// PURPOSE
//  Carry-propagate stage directly downstream of the 3:2 compressor group in the FMA datapath.
//  Takes the carry-save pair (s, cout) from the compressor group and resolves it into one binary sum.
//  Uses a 2-stage pipelined adder: the low slice is added in stage 1, its carry is registered,
//  and the high slice is added in stage 2.
//  Operand valid/ready handshake with full back-pressure; the result feeds normalisation.
// PARAMETERS
//  GRP_WIDTH  79  datapath width; must match the compressor group
//  LO_W       40  stage-1 slice width; stage 2 adds the remaining GRP_WIDTH-LO_W bits
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          s_in/c_in hold a valid carry-save pair
//  in_ready   out  1          stage accepts the pair this cycle
//  s_in       in   GRP_WIDTH  sum vector from the compressor group
//  c_in       in   GRP_WIDTH  shifted carry vector; bit 0 already holds the csign injection
//  out_valid  out  1          out_sum is valid
//  out_ready  in   1          consumer accepts out_sum this cycle
//  out_sum    out  GRP_WIDTH  (s_in + c_in) mod 2^GRP_WIDTH
//  out_neg    out  1          out_sum[GRP_WIDTH-1]
//  out_cout   out  1          carry out of bit GRP_WIDTH-1 (debug; discarded by the datapath)
// BEHAVIOUR
//  Stage 1 register set:
//   - v1
//   - lo_sum[LO_W-1:0]
//   - lo_c (carry out of the low slice)
//   - s_hi / c_hi (high operand slices, passed through unchanged)
//  Stage 2 register set: v2, out_sum, out_cout. The high-slice add is s_hi + c_hi + lo_c.
//  Handshake rules:
//   - adv2 = v1 & (~v2 | out_ready)
//   - in_ready = ~v1 | adv2 (combinational)
//   - Transfer in: in_valid & in_ready.
//   - Transfer out: out_valid & out_ready.
//  Valid updates:
//   - v1 <= in_valid & in_ready | (v1 & ~adv2)
//   - v2 <= adv2 | (v2 & ~out_ready)
//  Data registers load only on their transfer enable and otherwise hold. No bubble is inserted.
//  Latency is 2 cycles from the accept edge to out_valid. Throughput is 1 per cycle while out_ready=1.
//  Stalls:
//   - out_ready=0 with v2=1 freezes stage 2, and out_sum stays stable.
//   - Stage 1 still fills if empty, so 2 items are buffered before in_ready drops.
//  Simultaneous out and in transfer in the same cycle with both stages full is legal; no item is lost or duplicated.
//  Arithmetic: unsigned modular add. Two's-complement sign comes from out_neg; no rounding or sticky logic here.
//  Reset:
//   - v1, v2, out_valid, out_sum, out_cout and out_neg all go to 0.
//   - in_ready is 1 in the cycle after reset.
//   - Reset mid-operation drops in-flight items without emitting them.
//  out_* mirror the stage-2 registers; out_neg and out_lzc are derived combinationally from out_sum.
// CONFIGURATION
//  CSA_CPA_LZC_EN defined:
//   - Adds port out_lzc [$clog2(GRP_WIDTH)-1:0].
//   - out_lzc counts the bits of out_sum[GRP_WIDTH-2:0], from the MSB down, that equal out_neg.
//   - It is the normalisation shift; all-equal gives GRP_WIDTH-1.
//   - out_lzc is valid with out_valid and is 0 under reset.
//  CSA_CPA_LZC_EN undefined: the port and the counter logic are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package fma_pkg:
//   - GRP_WIDTH constant
//   - LZC width localparam
//   - typedef csa_pair_t {s, c}
//  Sub-module csa_cpa_slice (parameter W; inputs a, b, cin; outputs sum, cout) is instantiated twice, once per stage.
//  The leading-count logic is an inline function guarded by the macro.
// TESTING
//  1. s_in=1, c_in=1, out_ready=1 -> out_sum=2, out_neg=0, out_cout=0; out_valid exactly 2 cycles after accept.
//  2. s_in=2^40-1, c_in=1 -> out_sum=2^40 (carry across the slice boundary through lo_c).
//  3. s_in=all ones, c_in=1 -> out_sum=0, out_cout=1. s_in=2^78, c_in=0 -> out_neg=1.
//  4. out_ready=0, push 3 pairs (A,B,C) -> A,B accepted, in_ready=0 on C; raise out_ready -> A,B,C emerge in order, none lost.
//  5. rst asserted with v1=v2=1 -> next cycle out_valid=0, in_ready=1, out_sum=0; the following accept runs normally.
//  6. CSA_CPA_LZC_EN: out_sum=1 -> out_lzc=77; out_sum=all ones -> 78; out_sum=0 -> 78; out_sum=2^77 -> 0.

Source files
------------

// File: rtl/fma_pkg.sv
// rtl/fma_pkg.sv - shared FMA datapath constants and carry-save pair type
//
// Purpose : constants shared by the compressor group and the carry-propagate stage.
// Contents: GRP_WIDTH  datapath width of the compressor group output
//           LO_W       width of the first pipelined adder slice
//           LZC_W      width of the normalisation leading-count
//           csa_pair_t carry-save pair {s, c}

package fma_pkg;

    localparam int GRP_WIDTH = 79;
    localparam int LO_W      = 40;
    localparam int LZC_W     = $clog2(GRP_WIDTH);

    typedef struct packed {
        logic [GRP_WIDTH-1:0] s;
        logic [GRP_WIDTH-1:0] c;
    } csa_pair_t;

endpackage

// File: rtl/csa_cpa_slice.sv
// rtl/csa_cpa_slice.sv - W-bit ripple add slice with carry in/out
//
// Purpose : one slice of the pipelined carry-propagate adder.
// Ports   : a, b  [W-1:0] operands
//           cin   carry into bit 0
//           sum   [W-1:0] (a + b + cin) mod 2^W
//           cout  carry out of bit W-1

module csa_cpa_slice #(
    parameter int W = 40
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/csa_cpa_pipe.sv
// rtl/csa_cpa_pipe.sv - two-stage pipelined carry-propagate adder for the FMA CSA output
//
// Purpose : resolves the carry-save pair (s_in, c_in) into one binary sum. Stage 1 adds
//           the low LO_W bits and registers their carry; stage 2 adds the high slice
//           with that carry. valid/ready handshake with full back-pressure.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           in_valid/in_ready        operand handshake
//           s_in, c_in [GRP_WIDTH]   carry-save pair (c_in bit 0 holds the csign injection)
//           out_valid/out_ready      result handshake
//           out_sum [GRP_WIDTH]      (s_in + c_in) mod 2^GRP_WIDTH
//           out_neg                  out_sum MSB
//           out_cout                 carry out of the MSB (debug only)
//           out_lzc                  present only with CSA_CPA_LZC_EN: count of bits of
//                                    out_sum[GRP_WIDTH-2:0], from the top, equal to out_neg
// Macro   : CSA_CPA_LZC_EN enables out_lzc and its counter.

module csa_cpa_pipe #(
    parameter int GRP_WIDTH = fma_pkg::GRP_WIDTH,
    parameter int LO_W      = fma_pkg::LO_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [GRP_WIDTH-1:0]         s_in,
    input  logic [GRP_WIDTH-1:0]         c_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [GRP_WIDTH-1:0]         out_sum,
    output logic                         out_neg,
    output logic                         out_cout
`ifdef CSA_CPA_LZC_EN
   ,output logic [$clog2(GRP_WIDTH)-1:0] out_lzc
`endif
);

    import fma_pkg::*;

    localparam int HI_W = GRP_WIDTH - LO_W;

    csa_pair_t in_pair;
    assign in_pair = '{s: s_in, c: c_in};

    // stage 1 state
    logic            v1;
    logic [LO_W-1:0] lo_sum;
    logic            lo_c;
    logic [HI_W-1:0] s_hi;
    logic [HI_W-1:0] c_hi;

    // stage 2 state
    logic                 v2;
    logic [GRP_WIDTH-1:0] sum_q;
    logic                 cout_q;

    logic            adv2;
    logic            acc;
    logic [LO_W-1:0] lo_sum_d;
    logic            lo_c_d;
    logic [HI_W-1:0] hi_sum_d;
    logic            hi_c_d;

    // stage 2 takes stage 1's item when it is empty or draining this cycle, so a full
    // pipe can accept and emit in the same cycle without a bubble
    assign adv2     = v1 & (~v2 | out_ready);
    assign in_ready = ~v1 | adv2;
    assign acc      = in_valid & in_ready;

    csa_cpa_slice #(.W(LO_W)) u_lo (
        .a    (in_pair.s[LO_W-1:0]),
        .b    (in_pair.c[LO_W-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum_d),
        .cout (lo_c_d)
    );

    csa_cpa_slice #(.W(HI_W)) u_hi (
        .a    (s_hi),
        .b    (c_hi),
        .cin  (lo_c),
        .sum  (hi_sum_d),
        .cout (hi_c_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            lo_sum <= '0;
            lo_c   <= 1'b0;
            s_hi   <= '0;
            c_hi   <= '0;
            v2     <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            v1 <= acc | (v1 & ~adv2);
            v2 <= adv2 | (v2 & ~out_ready);
            if (acc) begin
                lo_sum <= lo_sum_d;
                lo_c   <= lo_c_d;
                s_hi   <= in_pair.s[GRP_WIDTH-1:LO_W];
                c_hi   <= in_pair.c[GRP_WIDTH-1:LO_W];
            end
            if (adv2) begin
                sum_q  <= {hi_sum_d, lo_sum};
                cout_q <= hi_c_d;
            end
        end
    end

    assign out_valid = v2;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_neg   = sum_q[GRP_WIDTH-1];

`ifdef CSA_CPA_LZC_EN
    localparam int CW = $clog2(GRP_WIDTH);

    // run length of sign-equal bits below the MSB; the normalisation shift amount
    function automatic logic [CW-1:0] sign_run(input logic [GRP_WIDTH-1:0] v);
        logic [CW-1:0] cnt;
        logic          run;
        cnt = '0;
        run = 1'b1;
        for (int i = GRP_WIDTH - 2; i >= 0; i--) begin
            if (run && (v[i] == v[GRP_WIDTH-1])) begin
                cnt = cnt + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
        return cnt;
    endfunction

    // gated by v2 so that the reset value (out_sum = 0) reads as 0 rather than a full run
    assign out_lzc = v2 ? sign_run(sum_q) : '0;
`endif

endmodule
